conf_write_arbiter: RTL and testbench
=====================================

Name: conf_write_arbiter

Overview:
- Owns the single write port of the layer configuration register file: memory pointer, FC log index, frame-by-frame execution flag, and so on.
- Shares that port between two requesters: the external host loader (SPI/APB bridge) and the on-chip layer scheduler, which rewrites pointers between frames.
- Each requester issues bursts: base address, length, then data beats on a valid/ready handshake.
- The block serialises the bursts, auto-increments the address, filters out-of-range writes and signals completion per burst.

Parameters:
- CONF_REGS, default CONF_REGISTERS_SIZE (package): number of config registers; valid addresses are 0..CONF_REGS-1.
- DATA_W, default 32: config word width.
- LEN_W, default 5: burst length field width; legal length 1..16, so bit 4 is used only for value 16.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- h_req  in  1  host burst request; held until h_ack
- h_addr  in  32  host burst base address; sampled with h_ack
- h_len  in  LEN_W  host burst length; sampled with h_ack
- h_ack  out  1  one-cycle grant pulse; burst accepted
- h_wvalid  in  1  host data beat valid
- h_wdata  in  DATA_W  host data beat
- h_wready  out  1  host beat accepted when h_wvalid && h_wready
- h_done  out  1  one-cycle pulse after the last host beat
- h_err  out  1  valid with h_done; at least one beat was out of range, or len==0
- s_req, s_addr, s_len, s_ack, s_wvalid, s_wdata, s_wready, s_done, s_err: same set for the scheduler
- wr_en_ext  out  1  config file write enable
- wr_addr_ext  out  32  config file write address
- wr_data_ext  out  DATA_W  config file write data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, rr_last=SEQ (host wins the first tie). Asserting reset mid-burst aborts the burst silently: no done pulse, and the partial writes stay in the config file.
- FSM states: IDLE, GRANT, BURST, DONE.
- IDLE:
  - If either req is high, select the winner. Round-robin: on a tie the winner is the requester other than rr_last; otherwise the sole requester wins.
  - Latch owner, base addr into cur_addr and len into remaining. Go to GRANT.
- GRANT (1 cycle): pulse the owner's ack.
  - If latched len==0, set err_flag and go to DONE.
  - Otherwise go to BURST.
- BURST:
  - The owner's wready=1; the other requester's wready=0.
  - On each accepted beat:
    - If cur_addr < CONF_REGS, register wr_en_ext=1 with wr_addr_ext=cur_addr and wr_data_ext=wdata, visible the next cycle. Otherwise no write and set err_flag.
    - cur_addr += 1; remaining -= 1.
  - When the beat that brings remaining to 0 is accepted, go to DONE.
  - wvalid low causes a stall of any length; there is no timeout.
- DONE (1 cycle): pulse owner done; err = err_flag. Clear err_flag, set rr_last=owner, return to IDLE.
- Latency:
  - Minimum burst of N beats: req at cycle t, ack at t+1, beats at t+2..t+N+1, done at t+N+2.
  - Last wr_en_ext at t+N+2.
  - Next grant no earlier than t+N+3.
- wr_en_ext is high only on the cycle after an in-range accepted beat; otherwise wr_en_ext=0. Address and data hold their last values when wr_en_ext=0.
- cur_addr is 32-bit and wraps modulo 2^32. Beats after the wrap go in range again and are written.
- A req that drops before ack is ignored if it is low when IDLE evaluates. After the grant, req is don't-care.
- Both requesters targeting the same address: the later burst's value persists.

Optional Feature:
- Macro: CONF_HOST_PRIORITY_EN.
- Defined: fixed priority. The host always wins when both req are high in IDLE, and the rr_last logic is removed.
- Undefined: round-robin as above.
- The rest of the behaviour is identical in both builds.

Decomposition:
- Package `parameters` (already holds CONF_REGISTERS_SIZE) gains:
  - conf_arb_state_t enum {IDLE, GRANT, BURST, DONE}
  - conf_owner_t enum {OWN_HOST, OWN_SEQ}
  - CONF_BURST_MAX=16
- One sub-module, conf_rr_pick: combinational 2-way arbiter. Inputs h_req, s_req, rr_last; output winner. It holds the `ifdef CONF_HOST_PRIORITY_EN variant.

Test Plan:
- Host burst, addr=0, len=3, data A/B/C, wvalid held high -> h_ack at t+1; wr_en_ext at t+3..t+5 with (0,A),(1,B),(2,C); h_done at t+5; h_err=0.
- h_req and s_req asserted in the same cycle from reset, len=1 each -> host served first, then scheduler; second tie -> scheduler first. With CONF_HOST_PRIORITY_EN -> host first both times.
- Scheduler burst, addr=CONF_REGS-1, len=2 -> exactly one write at CONF_REGS-1; s_done with s_err=1.
- Host burst len=0 -> h_ack, then h_done with h_err=1 two cycles after req; no wr_en_ext.
- Host len=4 with wvalid low for 3 cycles between beats 2 and 3 -> exactly 4 writes in order; s_req meanwhile sees no s_ack until the cycle after h_done.
- Reset pulsed after beat 1 of a len=4 burst -> outputs 0, no h_done; a fresh s_req after release is granted normally.

Source files
------------

// File: rtl/conf_write_arbiter_pkg.sv
// conf_write_arbiter_pkg: shared config-file sizing and arbiter types.
package parameters;
    localparam int CONF_REGISTERS_SIZE = 16;
    localparam int CONF_BURST_MAX = 16;
    typedef enum logic [1:0] {IDLE, GRANT, BURST, DONE} conf_arb_state_t;
    typedef enum logic {OWN_HOST, OWN_SEQ} conf_owner_t;
endpackage

// File: rtl/conf_write_arbiter_rr_pick.sv
// conf_rr_pick: 2-way requester pick; CONF_HOST_PRIORITY_EN selects fixed host priority.
module conf_rr_pick
    import parameters::*;
(
    input  logic        h_req,
    input  logic        s_req,
    input  conf_owner_t rr_last,
    output conf_owner_t winner
);
`ifdef CONF_HOST_PRIORITY_EN
    always_comb winner = h_req ? OWN_HOST : OWN_SEQ;
`else
    always_comb
        winner = (h_req && s_req) ? ((rr_last == OWN_HOST) ? OWN_SEQ : OWN_HOST)
               : h_req ? OWN_HOST : OWN_SEQ;
`endif
endmodule

// File: rtl/conf_write_arbiter.sv
// conf_write_arbiter: shares the config register file write port between host and scheduler bursts.
// Define CONF_HOST_PRIORITY_EN for fixed host priority instead of round-robin.
module conf_write_arbiter
    import parameters::*;
#(
    parameter int CONF_REGS = CONF_REGISTERS_SIZE,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_req,
    input  logic [31:0]       h_addr,
    input  logic [LEN_W-1:0]  h_len,
    output logic              h_ack,
    input  logic              h_wvalid,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_wready,
    output logic              h_done,
    output logic              h_err,
    input  logic              s_req,
    input  logic [31:0]       s_addr,
    input  logic [LEN_W-1:0]  s_len,
    output logic              s_ack,
    input  logic              s_wvalid,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_wready,
    output logic              s_done,
    output logic              s_err,
    output logic              wr_en_ext,
    output logic [31:0]       wr_addr_ext,
    output logic [DATA_W-1:0] wr_data_ext,
    output logic              busy
);
    localparam logic [31:0] ADDR_LIM = 32'(CONF_REGS);

    conf_arb_state_t   state_q, state_d;
    conf_owner_t       owner_q, owner_d, rr_last_q, rr_last_d, winner;
    logic [31:0]       cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              err_flag_q, err_flag_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              start, beat, in_range, wvalid_sel, host_own;
    logic [DATA_W-1:0] wdata_sel;

    conf_rr_pick u_pick (
        .h_req   (h_req),
        .s_req   (s_req),
        .rr_last (rr_last_q),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (h_req || s_req) ? GRANT : IDLE;
            GRANT:   state_d = (remaining_q == '0) ? DONE : BURST;
            BURST:   state_d = (beat && remaining_q == LEN_W'(1)) ? DONE : BURST;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        host_own = (owner_q == OWN_HOST);
        h_ack    = (state_q == GRANT) && host_own;
        s_ack    = (state_q == GRANT) && !host_own;
        h_wready = (state_q == BURST) && host_own;
        s_wready = (state_q == BURST) && !host_own;
        h_done   = (state_q == DONE) && host_own;
        s_done   = (state_q == DONE) && !host_own;
        h_err    = h_done && err_flag_q;
        s_err    = s_done && err_flag_q;
        busy     = (state_q != IDLE);
    end

    // Owner's wready is high for the whole BURST state, so a beat is just owner wvalid there.
    always_comb begin
        wvalid_sel  = (owner_q == OWN_HOST) ? h_wvalid : s_wvalid;
        wdata_sel   = (owner_q == OWN_HOST) ? h_wdata : s_wdata;
        beat        = (state_q == BURST) && wvalid_sel;
        in_range    = cur_addr_q < ADDR_LIM;
        start       = (state_q == IDLE) && (h_req || s_req);
        owner_d     = start ? winner : owner_q;
        cur_addr_d  = start ? ((winner == OWN_HOST) ? h_addr : s_addr)
                    : beat ? cur_addr_q + 32'd1 : cur_addr_q;
        remaining_d = start ? ((winner == OWN_HOST) ? h_len : s_len)
                    : beat ? remaining_q - LEN_W'(1) : remaining_q;
        err_flag_d  = (state_q == DONE) ? 1'b0
                    : (((state_q == GRANT) && remaining_q == '0) || (beat && !in_range)) ? 1'b1
                    : err_flag_q;
        rr_last_d   = (state_q == DONE) ? owner_q : rr_last_q;
        wr_en_d     = beat && in_range;
        wr_addr_d   = wr_en_d ? cur_addr_q : wr_addr_q;
        wr_data_d   = wr_en_d ? wdata_sel : wr_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_HOST;
            rr_last_q   <= OWN_SEQ;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            err_flag_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            err_flag_q  <= err_flag_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en_ext   = wr_en_q;
    assign wr_addr_ext = wr_addr_q;
    assign wr_data_ext = wr_data_q;
endmodule

// File: tb/tb_conf_write_arbiter.sv
// tb_conf_write_arbiter: directed scenario tasks for conf_write_arbiter with hand-computed expectations.
module tb_conf_write_arbiter;
    logic clk, reset;
    logic h_req, h_ack, h_wvalid, h_wready, h_done, h_err;
    logic s_req, s_ack, s_wvalid, s_wready, s_done, s_err;
    logic [31:0] h_addr, s_addr, h_wdata, s_wdata;
    logic [4:0] h_len, s_len;
    logic wr_en_ext, busy;
    logic [31:0] wr_addr_ext, wr_data_ext;

    typedef struct {int c; logic [31:0] a; logic [31:0] d;} wr_t;
    wr_t wlog[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;

    conf_write_arbiter dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_addr(h_addr), .h_len(h_len), .h_ack(h_ack),
        .h_wvalid(h_wvalid), .h_wdata(h_wdata), .h_wready(h_wready),
        .h_done(h_done), .h_err(h_err),
        .s_req(s_req), .s_addr(s_addr), .s_len(s_len), .s_ack(s_ack),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
        .s_done(s_done), .s_err(s_err),
        .wr_en_ext(wr_en_ext), .wr_addr_ext(wr_addr_ext), .wr_data_ext(wr_data_ext),
        .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wr_en_ext) wlog.push_back('{cyc, wr_addr_ext, wr_data_ext});

    task automatic do_burst(input bit sch, input logic [31:0] addr, input logic [4:0] len,
                            input logic [31:0] base, input int stall_at, input int stall_n,
                            output int ack_c, output int done_c, output bit err);
        int idx, st;
        logic rdy, v;
        idx = 0; st = 0; ack_c = -1; done_c = -1; err = 0;
        if (sch) begin s_req = 1; s_addr = addr; s_len = len; end
        else begin h_req = 1; h_addr = addr; h_len = len; end
        for (int n = 0; n < 200 && done_c < 0; n++) begin
            @(negedge clk);
            if (sch ? s_ack : h_ack) begin ack_c = cyc; if (sch) s_req = 0; else h_req = 0; end
            if (sch ? s_done : h_done) begin done_c = cyc; err = sch ? s_err : h_err; end
            rdy = sch ? s_wready : h_wready;
            v = rdy && !(idx == stall_at && st < stall_n);
            if (rdy && idx == stall_at && st < stall_n) st++;
            if (sch) begin s_wvalid = v; s_wdata = base + 32'(idx); end
            else begin h_wvalid = v; h_wdata = base + 32'(idx); end
            if (v) idx++;
        end
        if (sch) s_wvalid = 0; else h_wvalid = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({h_ack, h_wready, h_done, h_err, s_ack, s_wready, s_done, s_err, wr_en_ext, busy} !== 10'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {h_ack, h_wready, h_done, h_err, s_ack, s_wready, s_done, s_err, wr_en_ext, busy});
        end
        total++;
        if ({wr_addr_ext, wr_data_ext} !== 64'b0) begin
            bad++; $display("FAIL reset_wr got=%h/%h exp=0/0", wr_addr_ext, wr_data_ext);
        end
        reset = 1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_tie();
        logic [3:0] ord, exp_ord;
        int k, first, s;
`ifdef CONF_HOST_PRIORITY_EN
        exp_ord = 4'b1111;
`else
        exp_ord = 4'b1010;
`endif
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        ord = 0; k = 0; first = -1; s = cyc;
        h_req = 1; h_addr = 32'd4; h_len = 5'd1; h_wvalid = 1; h_wdata = 32'h11;
        s_req = 1; s_addr = 32'd5; s_len = 5'd1; s_wvalid = 1; s_wdata = 32'h22;
        for (int n = 0; n < 40 && k < 4; n++) begin
            @(negedge clk);
            if (h_ack || s_ack) begin
                if (k == 0) first = cyc;
                ord[3-k] = h_ack;
                k++;
            end
        end
        h_req = 0; s_req = 0;
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        h_wvalid = 0; s_wvalid = 0;
        @(negedge clk);
        total++;
        if (first !== s + 1) begin bad++; $display("FAIL tie_first_ack got=%0d exp=%0d", first - s, 1); end
        total++;
        if (ord !== exp_ord) begin bad++; $display("FAIL tie_order got=%b exp=%b", ord, exp_ord); end
    endtask

    task automatic test_host_burst();
        int s, a, d;
        bit e;
        wr_t w[$];
        s = cyc;
        do_burst(0, 32'd0, 5'd3, 32'hA0, 99, 0, a, d, e);
        foreach (wlog[i]) if (wlog[i].c >= s && wlog[i].c <= s + 20) w.push_back(wlog[i]);
        total++;
        if (a - s !== 1) begin bad++; $display("FAIL host_ack got=%0d exp=1", a - s); end
        total++;
        if (d - s !== 5) begin bad++; $display("FAIL host_done got=%0d exp=5", d - s); end
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL host_err got=%b exp=0", e); end
        total++;
        if (w.size() !== 3) begin bad++; $display("FAIL host_nwr got=%0d exp=3", w.size()); end
        for (int i = 0; i < w.size() && i < 3; i++) begin
            total++;
            if (w[i].c - s !== 3 + i || w[i].a !== 32'(i) || w[i].d !== 32'hA0 + 32'(i)) begin
                bad++; $display("FAIL host_wr%0d got=c%0d a%0h d%0h exp=c%0d a%0h d%0h",
                                i, w[i].c - s, w[i].a, w[i].d, 3 + i, i, 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_out_of_range();
        int s, a, d;
        bit e;
        wr_t w[$];
        s = cyc;
        do_burst(1, 32'd15, 5'd2, 32'h55, 99, 0, a, d, e);
        foreach (wlog[i]) if (wlog[i].c >= s && wlog[i].c <= s + 20) w.push_back(wlog[i]);
        total++;
        if (a - s !== 1 || d - s !== 4) begin bad++; $display("FAIL range_timing got=%0d/%0d exp=1/4", a - s, d - s); end
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL range_err got=%b exp=1", e); end
        total++;
        if (w.size() !== 1) begin bad++; $display("FAIL range_nwr got=%0d exp=1", w.size()); end
        else begin
            total++;
            if (w[0].c - s !== 3 || w[0].a !== 32'd15 || w[0].d !== 32'h55) begin
                bad++; $display("FAIL range_wr got=c%0d a%0h d%0h exp=c3 af d55", w[0].c - s, w[0].a, w[0].d);
            end
        end
    endtask

    task automatic test_len_zero();
        int s, a, d, n;
        bit e;
        s = cyc;
        do_burst(0, 32'd7, 5'd0, 32'h99, 99, 0, a, d, e);
        n = 0;
        foreach (wlog[i]) if (wlog[i].c >= s && wlog[i].c <= s + 20) n++;
        total++;
        if (a - s !== 1) begin bad++; $display("FAIL len0_ack got=%0d exp=1", a - s); end
        total++;
        if (d - s !== 2) begin bad++; $display("FAIL len0_done got=%0d exp=2", d - s); end
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL len0_err got=%b exp=1", e); end
        total++;
        if (n !== 0) begin bad++; $display("FAIL len0_nwr got=%0d exp=0", n); end
    endtask

    task automatic test_back_to_back();
        int s, a, d, sa, sd;
        bit e;
        wr_t w[$];
        logic [31:0] ea[5];
        logic [31:0] ed[5];
        ea = '{32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        ed = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'h5A};
        s = cyc; sa = -1; sd = -1;
        fork
            do_burst(0, 32'd4, 5'd4, 32'hB0, 2, 3, a, d, e);
            begin
                repeat (3) @(negedge clk);
                s_req = 1; s_addr = 32'd8; s_len = 5'd1; s_wvalid = 1; s_wdata = 32'h5A;
                for (int n = 0; n < 60 && sd < 0; n++) begin
                    @(negedge clk);
                    if (s_ack && sa < 0) begin sa = cyc; s_req = 0; end
                    if (s_done) sd = cyc;
                end
                s_wvalid = 0;
            end
        join
        @(negedge clk);
        foreach (wlog[i]) if (wlog[i].c >= s && wlog[i].c <= s + 40) w.push_back(wlog[i]);
        total++;
        if (a - s !== 1 || d - s !== 9) begin bad++; $display("FAIL b2b_host_timing got=%0d/%0d exp=1/9", a - s, d - s); end
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL b2b_host_err got=%b exp=0", e); end
        total++;
        if (sa - d !== 2) begin bad++; $display("FAIL b2b_sched_ack got=%0d exp=2 after h_done", sa - d); end
        total++;
        if (sd - sa !== 2) begin bad++; $display("FAIL b2b_sched_done got=%0d exp=2 after s_ack", sd - sa); end
        total++;
        if (w.size() !== 5) begin bad++; $display("FAIL b2b_nwr got=%0d exp=5", w.size()); end
        for (int i = 0; i < w.size() && i < 5; i++) begin
            total++;
            if (w[i].a !== ea[i] || w[i].d !== ed[i]) begin
                bad++; $display("FAIL b2b_wr%0d got=a%0h d%0h exp=a%0h d%0h", i, w[i].a, w[i].d, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int s, a, d, n;
        bit e, seen;
        s = cyc;
        h_req = 1; h_addr = 32'd10; h_len = 5'd4; h_wvalid = 1; h_wdata = 32'hC0;
        @(negedge clk);
        h_req = 0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (wr_en_ext !== 1'b1 || wr_addr_ext !== 32'd10 || wr_data_ext !== 32'hC0) begin
            bad++; $display("FAIL rst_beat0 got=%b a%0h d%0h exp=1 a a d c0", wr_en_ext, wr_addr_ext, wr_data_ext);
        end
        h_wdata = 32'hC1;
        @(negedge clk);
        reset = 0;
        #1;
        total++;
        if ({h_ack, h_wready, h_done, h_err, s_ack, s_wready, s_done, s_err, wr_en_ext, busy} !== 10'b0) begin
            bad++; $display("FAIL rst_mid_ctrl got=%b exp=0", {h_ack, h_wready, h_done, h_err, s_ack, s_wready, s_done, s_err, wr_en_ext, busy});
        end
        h_wvalid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (h_done || h_ack || busy) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_done got=%b exp=0", seen); end
        s = cyc;
        do_burst(1, 32'd3, 5'd1, 32'h77, 99, 0, a, d, e);
        n = 0;
        foreach (wlog[i]) if (wlog[i].c == s + 3 && wlog[i].a == 32'd3 && wlog[i].d == 32'h77) n++;
        total++;
        if (a - s !== 1 || d - s !== 3 || e !== 1'b0) begin
            bad++; $display("FAIL rst_fresh got=ack%0d done%0d err%b exp=ack1 done3 err0", a - s, d - s, e);
        end
        total++;
        if (n !== 1) begin bad++; $display("FAIL rst_fresh_wr got=%0d exp=1", n); end
    endtask

    initial begin
        reset = 0;
        h_req = 0; h_addr = 0; h_len = 0; h_wvalid = 0; h_wdata = 0;
        s_req = 0; s_addr = 0; s_len = 0; s_wvalid = 0; s_wdata = 0;
        @(negedge clk);
        test_reset();
        test_tie();
        test_host_burst();
        test_out_of_range();
        test_len_zero();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
